// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and limits for the Booth product accumulator
package booth_pkg;

  localparam int PROD_W    = 8;
  localparam int ACC_W_DEF = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic int acc_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

  localparam int ACC_MAX = acc_max(ACC_W_DEF);
  localparam int ACC_MIN = acc_min(ACC_W_DEF);

endpackage

// File: rtl/booth_sat_add.sv
// rtl/booth_sat_add.sv - combinational signed saturating adder, accumulator plus product
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(acc_max(ACC_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(acc_min(ACC_W));

  logic signed [ACC_W:0] sum;
  logic                  over_hi;
  logic                  under_lo;

  // One guard bit is enough: two in-range operands can never wrap at ACC_W+1 bits.
  always_comb begin
    sum      = $signed({acc[ACC_W-1], acc}) +
               $signed({{(ACC_W+1-PROD_W){addend[PROD_W-1]}}, addend});
    over_hi  = (sum > HI);
    under_lo = (sum < LO);
    ovf      = over_hi | under_lo;
    if (over_hi) begin
      result = HI[ACC_W-1:0];
    end else if (under_lo) begin
      result = LO[ACC_W-1:0];
    end else begin
      result = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - sums groups of LEN signed products into a saturating result
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_sat,
  output logic [3:0]        acc_cnt
);

  acc_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc_nxt, sum;
  logic             sat_nxt, step_ovf, accept;
  logic [3:0]       cnt_nxt;

  booth_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc    (acc_data),
    .addend (prod_data),
    .result (sum),
    .ovf    (step_ovf)
  );

  // Ready depends only on state and clear, never on prod_valid.
  assign prod_ready = (state == ACCUM) && !clear;
  assign acc_valid  = (state == HOLD);
  assign accept     = prod_valid && prod_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_data;
    sat_nxt   = acc_sat;
    cnt_nxt   = acc_cnt;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      sat_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_nxt = sum;
            sat_nxt = acc_sat | step_ovf;
            cnt_nxt = acc_cnt + 4'd1;
            if (cnt_nxt == 4'(LEN)) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ACCUM;
      acc_data <= '0;
      acc_sat  <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      acc_data <= acc_nxt;
      acc_sat  <= sat_nxt;
      acc_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - directed and table-driven checks of the product accumulator
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;

  logic        clr0 = 1'b0, pv0 = 1'b0, ar0 = 1'b1;
  logic [7:0]  pd0 = '0;
  logic        pr0, av0, as0;
  logic [11:0] ad0;
  logic [3:0]  ac0;

  logic        clr1 = 1'b0, pv1 = 1'b0, ar1 = 1'b1;
  logic [7:0]  pd1 = '0;
  logic        pr1, av1, as1;
  logic [7:0]  ad1;
  logic [3:0]  ac1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.ACC_W(12), .LEN(4)) dut0 (
    .clk(clk), .n_rst(n_rst), .clear(clr0),
    .prod_valid(pv0), .prod_ready(pr0), .prod_data(pd0),
    .acc_valid(av0), .acc_ready(ar0), .acc_data(ad0),
    .acc_sat(as0), .acc_cnt(ac0)
  );

  booth_product_accumulator #(.ACC_W(8), .LEN(4)) dut1 (
    .clk(clk), .n_rst(n_rst), .clear(clr1),
    .prod_valid(pv1), .prod_ready(pr1), .prod_data(pd1),
    .acc_valid(av1), .acc_ready(ar1), .acc_data(ad1),
    .acc_sat(as1), .acc_cnt(ac1)
  );

  typedef struct {
    logic pv;
    int   pd;
    logic ar;
    logic clr;
    logic ep;
    logic ev;
    int   ed;
    logic es;
    int   ec;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed0(input int p);
    pv0 = 1'b1;
    pd0 = 8'(p);
    step();
    pv0 = 1'b0;
  endtask

  task automatic feed1(input int p);
    pv1 = 1'b1;
    pd1 = 8'(p);
    step();
    pv1 = 1'b0;
  endtask

  task automatic sat_seq(input string name, input int p0, input int p1,
                         input int p2, input int p3, input int exp_d);
    feed1(p0);
    feed1(p1);
    feed1(p2);
    feed1(p3);
    chk({name, "_valid"}, int'(av1), 1);
    chk({name, "_data"}, int'($signed(ad1)), exp_d);
    chk({name, "_sat"}, int'(as1), 1);
    step();
    chk({name, "_done"}, int'(av1), 0);
  endtask

  initial begin
    int  a, b, gap, ref_sum, waited;
    // {pv, pd, ar, clr, exp prod_ready, exp valid, exp data, exp sat, exp cnt}
    vecs[0]  = '{1'b1,  49, 1'b1, 1'b0, 1'b1, 1'b0,   49, 1'b0, 1};
    vecs[1]  = '{1'b1, -56, 1'b1, 1'b0, 1'b1, 1'b0,   -7, 1'b0, 2};
    vecs[2]  = '{1'b1,  64, 1'b1, 1'b0, 1'b1, 1'b0,   57, 1'b0, 3};
    vecs[3]  = '{1'b1,   1, 1'b1, 1'b0, 1'b1, 1'b1,   58, 1'b0, 4};
    vecs[4]  = '{1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b1,   58, 1'b0, 4};
    vecs[5]  = '{1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b1,   58, 1'b0, 4};
    vecs[6]  = '{1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b1,   58, 1'b0, 4};
    vecs[7]  = '{1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b1,   58, 1'b0, 4};
    vecs[8]  = '{1'b1,   5, 1'b0, 1'b0, 1'b0, 1'b1,   58, 1'b0, 4};
    vecs[9]  = '{1'b1,   5, 1'b1, 1'b0, 1'b0, 1'b0,    0, 1'b0, 0};
    vecs[10] = '{1'b1,   5, 1'b1, 1'b0, 1'b1, 1'b0,    5, 1'b0, 1};
    vecs[11] = '{1'b1,   7, 1'b1, 1'b0, 1'b1, 1'b0,   12, 1'b0, 2};
    vecs[12] = '{1'b0,   9, 1'b1, 1'b0, 1'b1, 1'b0,   12, 1'b0, 2};
    vecs[13] = '{1'b1,   3, 1'b1, 1'b0, 1'b1, 1'b0,   15, 1'b0, 3};
    vecs[14] = '{1'b1, 100, 1'b1, 1'b1, 1'b0, 1'b0,    0, 1'b0, 0};
    vecs[15] = '{1'b1, -10, 1'b1, 1'b0, 1'b1, 1'b0,  -10, 1'b0, 1};
    vecs[16] = '{1'b1, -20, 1'b1, 1'b0, 1'b1, 1'b0,  -30, 1'b0, 2};
    vecs[17] = '{1'b1, -30, 1'b1, 1'b0, 1'b1, 1'b0,  -60, 1'b0, 3};
    vecs[18] = '{1'b1, -40, 1'b0, 1'b0, 1'b1, 1'b1, -100, 1'b0, 4};
    vecs[19] = '{1'b0,   0, 1'b0, 1'b1, 1'b0, 1'b0,    0, 1'b0, 0};
    vecs[20] = '{1'b0,   0, 1'b1, 1'b0, 1'b1, 1'b0,    0, 1'b0, 0};

    #12;
    chk("rst_valid", int'(av0), 0);
    chk("rst_data", int'(ad0), 0);
    chk("rst_sat", int'(as0), 0);
    chk("rst_cnt", int'(ac0), 0);
    chk("rst_ready", int'(pr0), 1);
    chk("rst_ready_w8", int'(pr1), 1);
    @(negedge clk);
    n_rst = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      pv0  = vecs[i].pv;
      pd0  = 8'(vecs[i].pd);
      ar0  = vecs[i].ar;
      clr0 = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_pready", i), int'(pr0), int'(vecs[i].ep));
      step();
      chk($sformatf("v%0d_valid", i), int'(av0), int'(vecs[i].ev));
      chk($sformatf("v%0d_data", i), int'($signed(ad0)), vecs[i].ed);
      chk($sformatf("v%0d_sat", i), int'(as0), int'(vecs[i].es));
      chk($sformatf("v%0d_cnt", i), int'(ac0), vecs[i].ec);
    end
    pv0 = 1'b0; clr0 = 1'b0; ar0 = 1'b1;

    // Asynchronous reset in the middle of a sum, away from any clock edge.
    feed0(49);
    feed0(-56);
    chk("mid_cnt", int'(ac0), 2);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_cnt", int'(ac0), 0);
    chk("arst_data", int'(ad0), 0);
    chk("arst_valid", int'(av0), 0);
    chk("arst_ready", int'(pr0), 1);
    @(negedge clk);
    n_rst = 1'b1;
    feed0(1);
    feed0(2);
    feed0(3);
    feed0(4);
    chk("post_rst_valid", int'(av0), 1);
    chk("post_rst_data", int'($signed(ad0)), 10);
    step();

    sat_seq("sat_pos", 64, 64, -1, 0, 126);
    sat_seq("sat_neg", -56, -56, -56, -56, -128);

    // Products of random signed 4-bit operands, with random idle gaps.
    for (int r = 0; r < 3; r++) begin
      ref_sum = 0;
      for (int k = 0; k < 4; k++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) step();
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        if (a > 7) a -= 16;
        if (b > 7) b -= 16;
        ref_sum += a * b;
        feed0(a * b);
      end
      waited = 0;
      while (!av0 && waited < 8) begin
        step();
        waited++;
      end
      chk($sformatf("gap%0d_valid", r), int'(av0), 1);
      chk($sformatf("gap%0d_data", r), int'($signed(ad0)), ref_sum);
      chk($sformatf("gap%0d_sat", r), int'(as0), 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
